onewire_slave: RTL and testbench
================================

# onewire_slave

1-Wire bus responder: the device end of the link driven by the sockit_owm master. Detects master reset pulses, answers with a presence pulse, samples master write slots into bytes and drives read slots from a loaded byte. Sits between the synchronized open-drain bus pad and a local byte-level register or application interface; all timing is counted in clock cycles by an instance of the shared counter.

## Interface
Parameters:
- CW, 9: timing counter width; every T* value below must be < 2**CW.
- TRST, 400: line-low length (cycles) at which a bus reset is detected.
- TPDH, 30: delay from reset-pulse rising edge to presence start.
- TPDL, 120: presence pulse length.
- TSMP, 30: sample point after a slot falling edge.
- TDRV, 45: low drive length when transmitting a 0 bit; TSMP < TDRV < TRST.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- owr_i  input  1  bus level, already synchronized to clk
- owr_e  output  1  1 = pull bus low (pad is open drain)
- bus_rst  output  1  one-cycle pulse: master reset detected
- rx_dat  output  8  last received byte, LSB first on the wire
- rx_vld  output  1  one-cycle pulse: rx_dat updated
- tx_dat  input  8  byte to send in the next 8 slots
- tx_ld  input  1  load tx_dat; honoured only when tx_rdy=1
- tx_rdy  output  1  no transmit byte pending

## Operation
- Reset values: owr_e=0, bus_rst=0, rx_dat=8'h00, rx_vld=0, tx_rdy=1, state IDLE, bit index 0.
- Falling edge = previous sampled owr_i 1, current 0; timing counter cleared on that cycle, enabled while in LOW/SLOT/PRS_WAIT/PRS.
- States:
  - IDLE: falling edge -> SLOT.
  - SLOT: if transmit pending and current tx bit is 0, owr_e=1 until count reaches TDRV. At count==TSMP shift owr_i into rx shift register (LSB first), bit index +1. After TDRV, or after TSMP for a 1/receive bit, -> LOW-watch: line still low at count==TRST -> LOW; rising edge -> IDLE.
  - LOW: waits for rising edge; then bus_rst pulses, counter cleared -> PRS_WAIT.
  - PRS_WAIT: count==TPDH -> PRS, counter cleared.
  - PRS: owr_e=1 for TPDL cycles -> IDLE.
- Byte completion: 8th sample loads rx_dat, pulses rx_vld; if transmitting, transmit pending cleared, tx_rdy=1.
- Every slot is both sampled and (if pending) driven; transmitted bits are received back identically.
- tx_ld with tx_rdy=1 latches tx_dat, tx_rdy=0; tx_ld with tx_rdy=0 ignored. Load must precede a byte boundary (bit index 0); load mid-byte is held until index 0.
- Bus reset (entering LOW) discards partial rx byte, bit index -> 0, transmit pending cleared, tx_rdy=1.
- Falling edge during PRS_WAIT/PRS ignored.

## Timing
- bus_rst: cycle after the rising edge ending a low of >= TRST cycles.
- owr_e for presence: asserted TPDH+1 cycles after that rising edge, held exactly TPDL cycles.
- Slot sample at falling edge + TSMP cycles; rx_vld 1 cycle after 8th sample.
- Transmit-0 drive: owr_e high from cycle after falling edge for TDRV cycles.
- Low of TRST-1 cycles is a slot, not a reset.
- Async rst mid-drive releases owr_e immediately.

## Structure
- Package onewire_pkg: state enum (IDLE, SLOT, LOW, PRS_WAIT, PRS) and default timing constants.
- Sub-module: counter (CW-bit, ena/clr) as the timing counter.

## Test plan
- Reset pulse low 480 cycles -> bus_rst one cycle after release; owr_e low 120 cycles starting 31 cycles after release.
- Write 8'hA5 with 10-cycle lows for 1, 60-cycle lows for 0 -> rx_vld once, rx_dat=8'hA5.
- tx_ld 8'h3C then 8 read slots (5-cycle master low) -> sampled bus bits 0,0,1,1,1,1,0,0; tx_rdy=1 after 8th; rx_dat=8'h3C.
- Reset pulse after 4 bits of a write -> no rx_vld; following full byte 8'h01 received correctly.
- Low of 399 cycles -> treated as 0 bit, no bus_rst; 400 -> bus_rst.
- Async rst asserted while driving presence -> owr_e=0 same cycle, all outputs at reset values.

Source files
------------

// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire slave: FSM state encoding and default bus timing.
// Timing values are in core clock cycles.
package onewire_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SLOT     = 3'd1,
    LOW      = 3'd2,
    PRS_WAIT = 3'd3,
    PRS      = 3'd4
  } state_e;

  localparam int unsigned DEF_CW   = 9;
  localparam int unsigned DEF_TRST = 400;
  localparam int unsigned DEF_TPDH = 30;
  localparam int unsigned DEF_TPDL = 120;
  localparam int unsigned DEF_TSMP = 30;
  localparam int unsigned DEF_TDRV = 45;

endpackage

// File: rtl/onewire_slave_counter.sv
// Free-running timing counter with synchronous clear (priority) and count enable.
// Count is visible the cycle after clr/ena; wraps at 2**CW; no backpressure.
module onewire_slave_counter
  import onewire_pkg::*;
#(
  parameter int unsigned CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (ena_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/onewire_slave.sv
// 1-Wire device end: reset/presence, write-slot sampling into rx bytes, read-slot driving from a tx byte.
// Sample TSMP cycles after a falling edge, rx_vld one cycle later; tx_ld is accepted only while tx_rdy=1.
module onewire_slave
  import onewire_pkg::*;
#(
  parameter int unsigned CW   = DEF_CW,
  parameter int unsigned TRST = DEF_TRST,
  parameter int unsigned TPDH = DEF_TPDH,
  parameter int unsigned TPDL = DEF_TPDL,
  parameter int unsigned TSMP = DEF_TSMP,
  parameter int unsigned TDRV = DEF_TDRV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       owr_i,
  output logic       owr_e,
  output logic       bus_rst,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  input  logic [7:0] tx_dat,
  input  logic       tx_ld,
  output logic       tx_rdy
);

  // The counter reads 0 on the cycle after the event that cleared it, so a
  // point "N cycles after the event" is a count of N-1.
  localparam logic [CW-1:0] C_SMP     = CW'(TSMP - 1);
  localparam logic [CW-1:0] C_SMP_END = CW'(TSMP);
  localparam logic [CW-1:0] C_DRV     = CW'(TDRV);
  localparam logic [CW-1:0] C_RST     = CW'(TRST - 2);
  localparam logic [CW-1:0] C_PDH     = CW'(TPDH - 1);
  localparam logic [CW-1:0] C_PDL     = CW'(TPDL - 1);

  state_e        state_q, state_d;
  logic          owr_q;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic [7:0]    rx_dat_q, rx_dat_d;
  logic          rx_vld_q, rx_vld_d;
  logic          bus_rst_q, bus_rst_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_full_q, tx_full_d;
  logic          tx_act_q, tx_act_d;
  logic          drv_q, drv_d;
  logic [CW-1:0] cnt;
  logic          cnt_clr;
  logic          cnt_ena;
  logic          fall;
  logic          slot_done;

  onewire_slave_counter #(.CW(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .ena_i (cnt_ena),
    .clr_i (cnt_clr),
    .cnt_o (cnt)
  );

  assign fall      = owr_q & ~owr_i;
  assign cnt_ena   = (state_q != IDLE);
  assign slot_done = drv_q ? (cnt >= C_DRV) : (cnt >= C_SMP_END);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    rx_sr_d   = rx_sr_q;
    rx_dat_d  = rx_dat_q;
    rx_vld_d  = 1'b0;
    bus_rst_d = 1'b0;
    tx_byte_d = tx_byte_q;
    tx_full_d = tx_full_q;
    tx_act_d  = tx_act_q;
    drv_d     = drv_q;
    cnt_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = SLOT;
          cnt_clr = 1'b1;
          // A loaded byte only starts on a byte boundary.
          if (bit_idx_q == 3'd0) begin
            tx_act_d = tx_full_q;
          end
          drv_d = tx_act_d & ~tx_byte_q[bit_idx_q];
        end
      end
      SLOT: begin
        if (cnt == C_SMP) begin
          rx_sr_d   = {owr_i, rx_sr_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            rx_dat_d = rx_sr_d;
            rx_vld_d = 1'b1;
            if (tx_act_q) begin
              tx_act_d  = 1'b0;
              tx_full_d = 1'b0;
            end
          end
        end
        if (!owr_i && cnt == C_RST) begin
          state_d   = LOW;
          bit_idx_d = 3'd0;
          rx_sr_d   = 8'h00;
          tx_act_d  = 1'b0;
          tx_full_d = 1'b0;
          drv_d     = 1'b0;
        end else if (owr_i && slot_done) begin
          state_d = IDLE;
        end
      end
      LOW: begin
        if (owr_i) begin
          state_d   = PRS_WAIT;
          bus_rst_d = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      PRS_WAIT: begin
        if (cnt == C_PDH) begin
          state_d = PRS;
          cnt_clr = 1'b1;
        end
      end
      PRS: begin
        if (cnt == C_PDL) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_ld && !tx_full_q) begin
      tx_byte_d = tx_dat;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owr_q     <= 1'b1;
      bit_idx_q <= 3'd0;
      rx_sr_q   <= 8'h00;
      rx_dat_q  <= 8'h00;
      rx_vld_q  <= 1'b0;
      bus_rst_q <= 1'b0;
      tx_byte_q <= 8'h00;
      tx_full_q <= 1'b0;
      tx_act_q  <= 1'b0;
      drv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owr_q     <= owr_i;
      bit_idx_q <= bit_idx_d;
      rx_sr_q   <= rx_sr_d;
      rx_dat_q  <= rx_dat_d;
      rx_vld_q  <= rx_vld_d;
      bus_rst_q <= bus_rst_d;
      tx_byte_q <= tx_byte_d;
      tx_full_q <= tx_full_d;
      tx_act_q  <= tx_act_d;
      drv_q     <= drv_d;
    end
  end

  // Decoded from state so an async reset releases the bus at once.
  assign owr_e   = (state_q == PRS) || (state_q == SLOT && drv_q && cnt < C_DRV);
  assign bus_rst = bus_rst_q;
  assign rx_dat  = rx_dat_q;
  assign rx_vld  = rx_vld_q;
  assign tx_rdy  = ~tx_full_q;

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: an open-drain bus master drives slot/reset lows while a
// bit/byte-level model of the device predicts every response.
module tb_onewire_slave;

  localparam int TRST = 400;
  localparam int TPDH = 30;
  localparam int TPDL = 120;
  localparam int TSMP = 30;
  localparam int TDRV = 45;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_low = 1'b0;
  logic       owr_i;
  logic       owr_e;
  logic       bus_rst;
  logic [7:0] rx_dat;
  logic       rx_vld;
  logic [7:0] tx_dat = 8'h00;
  logic       tx_ld = 1'b0;
  logic       tx_rdy;

  assign owr_i = ~(m_low | owr_e);

  onewire_slave #(
    .CW(9), .TRST(TRST), .TPDH(TPDH), .TPDL(TPDL), .TSMP(TSMP), .TDRV(TDRV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .owr_i   (owr_i),
    .owr_e   (owr_e),
    .bus_rst (bus_rst),
    .rx_dat  (rx_dat),
    .rx_vld  (rx_vld),
    .tx_dat  (tx_dat),
    .tx_ld   (tx_ld),
    .tx_rdy  (tx_rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Device model: partial byte as a bit vector plus a count, tx byte and flags.
  logic [7:0] m_rx;
  int         m_nbits;
  logic [7:0] m_tx_byte;
  bit         m_tx_pend;
  bit         m_tx_act;

  // Observations over one run of the master, indexed by cycle t from the falling edge.
  logic       obs_bus;
  int         obs_e_cnt, obs_e_first, obs_p_first, obs_p_cnt;
  int         obs_rst_n, obs_rst_t, obs_vld_n, obs_vld_t;
  logic [7:0] obs_vld_dat;

  task automatic model_reset();
    m_rx = 8'h00; m_nbits = 0; m_tx_pend = 0; m_tx_act = 0;
  endtask

  task automatic run_low(input int len, input int total);
    obs_bus = 1'b1; obs_e_cnt = 0; obs_e_first = -1; obs_p_first = -1; obs_p_cnt = 0;
    obs_rst_n = 0; obs_rst_t = -1; obs_vld_n = 0; obs_vld_t = -1; obs_vld_dat = 8'h00;
    for (int t = 0; t < total; t++) begin
      @(posedge clk); #1;
      m_low = (t < len);
      @(negedge clk);
      if (t == TSMP) obs_bus = owr_i;
      if (owr_e) begin
        obs_e_cnt++;
        if (obs_e_first < 0) obs_e_first = t;
        if (t >= len) begin
          obs_p_cnt++;
          if (obs_p_first < 0) obs_p_first = t;
        end
      end
      if (bus_rst) begin obs_rst_n++; obs_rst_t = t; end
      if (rx_vld) begin obs_vld_n++; obs_vld_t = t; obs_vld_dat = rx_dat; end
    end
    m_low = 1'b0;
  endtask

  task automatic tx_load(input logic [7:0] b);
    @(posedge clk); #1;
    tx_dat = b; tx_ld = 1'b1;
    if (!m_tx_pend) begin m_tx_pend = 1; m_tx_byte = b; end
    @(posedge clk); #1;
    tx_ld = 1'b0;
    @(negedge clk);
    check("tx_rdy_after_load", tx_rdy, 1'b0);
  endtask

  // One master low shorter than a reset: a time slot.
  task automatic slot(input int len);
    bit drv0;
    bit smp;
    int total;
    if (m_nbits == 0 && m_tx_pend) m_tx_act = 1;
    drv0  = m_tx_act && !m_tx_byte[m_nbits];
    smp   = !(drv0 || len > TSMP);
    total = ((len > TDRV) ? len : TDRV) + 6 + int'($urandom_range(0, 4));
    run_low(len, total);
    if (m_tx_act) check("slot_sample_bit", obs_bus, smp);
    check("slot_drive_len", obs_e_cnt, drv0 ? TDRV : 0);
    if (drv0) check("slot_drive_start", obs_e_first, 1);
    check("slot_no_bus_rst", obs_rst_n, 0);
    m_rx[m_nbits] = smp;
    m_nbits++;
    if (m_nbits == 8) begin
      check("byte_vld_cnt", obs_vld_n, 1);
      check("byte_vld_time", obs_vld_t, TSMP + 1);
      check("byte_rx_dat", obs_vld_dat, m_rx);
      m_nbits = 0;
      if (m_tx_act) begin m_tx_act = 0; m_tx_pend = 0; end
    end else begin
      check("slot_no_vld", obs_vld_n, 0);
    end
    check("slot_tx_rdy", tx_rdy, !m_tx_pend);
  endtask

  // A master low of at least TRST: bus reset and presence.
  task automatic bus_reset(input int len);
    bit drv0;
    bit exp_vld;
    if (m_nbits == 0 && m_tx_pend) m_tx_act = 1;
    drv0 = m_tx_act && !m_tx_byte[m_nbits];
    exp_vld = (m_nbits == 7);
    m_rx[7] = 1'b0;
    run_low(len, len + TPDH + TPDL + 8);
    check("rst_pulse_cnt", obs_rst_n, 1);
    check("rst_pulse_time", obs_rst_t, len + 1);
    check("presence_start", obs_p_first, len + TPDH + 1);
    check("presence_len", obs_p_cnt, TPDL);
    check("rst_total_drive", obs_e_cnt, TPDL + (drv0 ? TDRV : 0));
    check("rst_vld_cnt", obs_vld_n, exp_vld ? 1 : 0);
    if (exp_vld) check("rst_vld_dat", obs_vld_dat, m_rx);
    model_reset();
    check("rst_tx_rdy", tx_rdy, 1'b1);
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) slot(b[i] ? 10 : 60);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    bit b;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_owr_e", owr_e, 1'b0);
    check("reset_bus_rst", bus_rst, 1'b0);
    check("reset_rx_dat", rx_dat, 8'h00);
    check("reset_rx_vld", rx_vld, 1'b0);
    check("reset_tx_rdy", tx_rdy, 1'b1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    bus_reset(480);
    write_byte(8'hA5);

    tx_load(8'h3C);
    tx_load(8'hFF);
    for (int i = 0; i < 8; i++) slot(5);

    slot(10); slot(10); slot(60); slot(10);
    bus_reset(480);
    write_byte(8'h01);

    slot(TRST - 1);
    bus_reset(TRST);

    slot(60); slot(10); slot(10);
    tx_load(8'hC6);
    for (int i = 0; i < 5; i++) slot(($urandom_range(0, 1) == 1) ? 8 : 70);
    for (int i = 0; i < 8; i++) slot(int'($urandom_range(1, 10)));

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 13));
      if (op == 0) begin
        bus_reset(int'($urandom_range(TRST, TRST + 80)));
      end else if (op <= 2) begin
        tx_load(8'($urandom_range(0, 255)));
      end else if (m_tx_pend && op <= 10) begin
        slot(int'($urandom_range(1, 10)));
      end else begin
        b = 1'($urandom_range(0, 1));
        slot(b ? int'($urandom_range(1, 15)) : int'($urandom_range(TSMP + 2, 120)));
      end
    end

    tx_load(8'h5A);
    run_low(480, 480 + TPDH + 1 + 20);
    check("async_pre_rst_pulse", obs_rst_n, 1);
    check("async_pre_presence", obs_p_first, 480 + TPDH + 1);
    check("async_pre_owr_e", owr_e, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_owr_e", owr_e, 1'b0);
    check("async_bus_rst", bus_rst, 1'b0);
    check("async_rx_dat", rx_dat, 8'h00);
    check("async_rx_vld", rx_vld, 1'b0);
    check("async_tx_rdy", tx_rdy, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    write_byte(8'h96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
